mux_out_fifo: RTL and testbench
===============================

Name: mux_out_fifo

Overview:
- Downstream buffer stage for the 8-bit mux datapath.
- Captures each mux output sample presented with in_valid and holds it in a DEPTH-entry synchronous FIFO.
- Hands samples to the consumer over a valid/ready interface.
- Decouples the free-running mux from a stalling consumer and flags lost samples.

Parameters:
- DATA_W, 8: sample width; matches the mux data width.
- DEPTH, 8: number of entries; power of 2, minimum 2.
- AW, log2(DEPTH): pointer width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- in_data  in  DATA_W  mux output sample.
- in_valid  in  1  sample present this cycle.
- in_ready  out  1  FIFO can accept (not full).
- out_data  out  DATA_W  head entry; meaningful only when out_valid=1.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer takes head this cycle.
- count  out  AW+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a sample was offered while full.

Behaviour:
- Reset: one clock synchronous, active-low (rst_n sampled on rising clk edge).
  - While rst_n=0 at an edge: wr_ptr=0, rd_ptr=0, count=0, overflow=0, so out_valid=0 and in_ready=1 next cycle.
  - Storage contents are not reset; out_data is don't-care while out_valid=0.
- push = in_valid & in_ready; pop = out_valid & out_ready. Both are evaluated on the same edge.
- in_ready = (count != DEPTH); out_valid = (count != 0). Both decode combinationally from registered count.
- Read path is first-word-fall-through: out_data = mem[rd_ptr] combinationally.
  - A sample pushed at edge N is visible on out_data/out_valid after edge N.
  - There is no bypass when empty: minimum latency is one cycle.
- Pointers wrap modulo DEPTH with no special case.
- count update rules:
  - push only: +1.
  - pop only: -1.
  - both: unchanged, with write to wr_ptr and read advance of rd_ptr in the same cycle.
  - neither: hold.
- Full boundary: in_ready=0, so no push happens even if out_ready=1 that cycle. The slot frees next cycle; there is no write-through on full.
- Empty boundary: out_ready ignored (pop=0); a simultaneous push proceeds normally.
- overflow is set on any edge where in_valid=1 and in_ready=0. It is cleared only by reset, and the offered sample is discarded.
- Reset mid-operation: all queued data is dropped. The first push after reset lands at entry 0.
- No X propagation: out_valid, in_ready and count are always defined after the first reset edge.

Optional Feature:
- Macro: MUX_OUT_FIFO_DROP_CNT_EN.
- Defined:
  - Adds output drop_cnt [7:0].
  - drop_cnt increments on every edge where in_valid=1 and in_ready=0.
  - It saturates at 255 and resets to 0 with rst_n.
  - overflow is still present.
- Undefined: port and counter are absent; overflow is the only loss indicator.

Decomposition:
- Shared package mux_pkg:
  - localparam MUX_DATA_W=8, reused by the mux and this FIFO.
  - localparam MUX_FIFO_DEPTH=8.
  - typedef mux_data_t (logic [MUX_DATA_W-1:0]).
- One natural sub-module: mux_fifo_ctrl, holding the pointer/count/flag logic.
  - Inputs: push, pop.
  - Outputs: wr_ptr, rd_ptr, count, full, empty.
  - The top keeps the storage array and the handshake gating.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, release -> count=0, out_valid=0, in_ready=1, overflow=0.
- Single sample: push in_data=8'h0A with out_ready=0 -> next cycle out_valid=1, out_data=8'h0A, count=1. Then out_ready=1 for 1 cycle -> count=0, out_valid=0.
- Fill and overflow, out_ready=0 throughout:
  - push 8'h0A..8'h11 (8 samples) -> count=8, in_ready=0.
  - 9th offer 8'h12 -> overflow=1, count stays 8, 8'h12 never appears.
  - With the macro defined, drop_cnt=1.
- Drain order: from full, out_ready=1 for 8 cycles -> out_data sequence 8'h0A..8'h11 in order, then count=0.
- Simultaneous push/pop at count=3:
  - push 8'hAC with out_ready=1 -> count stays 3, head advances.
  - pointers wrap correctly after 20 cycles of continuous push/pop, with no data reorder.
- Reset mid-stream: at count=5 assert rst_n=0 for 1 cycle -> count=0, overflow=0, out_valid=0. The next push 8'h55 appears as head one cycle later.

Source files
------------

// File: rtl/mux_pkg.sv
// ----------------------------------------------------------------------------
// mux_pkg
//   Constants and types shared by the 8-bit mux datapath and the FIFO that
//   buffers its output.
//
//   MUX_DATA_W     : width of one mux output sample
//   MUX_FIFO_DEPTH : default number of FIFO entries (power of 2, >= 2)
//   mux_data_t     : one mux sample
// ----------------------------------------------------------------------------
package mux_pkg;

  localparam int MUX_DATA_W     = 8;
  localparam int MUX_FIFO_DEPTH = 8;

  typedef logic [MUX_DATA_W-1:0] mux_data_t;

endpackage : mux_pkg

// File: rtl/mux_fifo_ctrl.sv
// ----------------------------------------------------------------------------
// mux_fifo_ctrl
//   Pointer and occupancy bookkeeping for mux_out_fifo. It holds no data.
//   The caller must already have qualified push and pop: push only when
//   not full, and pop only when not empty.
//
//   Ports:
//     clk     in   rising-edge clock
//     rst_n   in   synchronous active-low reset
//     push    in   write one entry at wr_ptr this edge
//     pop     in   retire the entry at rd_ptr this edge
//     wr_ptr  out  AW    next slot to write
//     rd_ptr  out  AW    current head slot
//     count   out  AW+1  occupancy, 0..DEPTH
//     full    out  count == DEPTH
//     empty   out  count == 0
// ----------------------------------------------------------------------------
module mux_fifo_ctrl
  import mux_pkg::*;
#(
  parameter int  DEPTH = MUX_FIFO_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  output logic [AW-1:0] wr_ptr,
  output logic [AW-1:0] rd_ptr,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q,  count_d;

  // DEPTH is a power of two, so the pointers wrap naturally on overflow of
  // their AW-bit width. No explicit modulo is needed.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;  // simultaneous push/pop, or idle
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign wr_ptr = wr_ptr_q;
  assign rd_ptr = rd_ptr_q;
  assign count  = count_q;
  assign full   = (count_q == (AW+1)'(DEPTH));
  assign empty  = (count_q == '0);

endmodule : mux_fifo_ctrl

// File: rtl/mux_out_fifo.sv
// ----------------------------------------------------------------------------
// mux_out_fifo
//   Downstream buffer for the free-running 8-bit mux. Samples offered with
//   in_valid are queued in a DEPTH-entry first-word-fall-through FIFO. The
//   consumer drains them over a valid/ready interface. Samples offered while
//   the FIFO is full are discarded, and the loss is flagged.
//
//   Optional build macro MUX_OUT_FIFO_DROP_CNT_EN adds the drop_cnt output,
//   a saturating count of discarded samples.
//
//   Ports:
//     clk        in   rising-edge clock
//     rst_n      in   synchronous active-low reset
//     in_data    in   DATA_W  mux output sample
//     in_valid   in   sample present this cycle
//     in_ready   out  FIFO can accept (not full)
//     out_data   out  DATA_W  head entry, meaningful while out_valid=1
//     out_valid  out  FIFO non-empty
//     out_ready  in   consumer takes the head this cycle
//     count      out  AW+1  occupancy, 0..DEPTH
//     overflow   out  sticky: a sample was offered while full
//     drop_cnt   out  [7:0] saturating dropped-sample count (macro only)
// ----------------------------------------------------------------------------
module mux_out_fifo
  import mux_pkg::*;
#(
  parameter int  DATA_W = MUX_DATA_W,
  parameter int  DEPTH  = MUX_FIFO_DEPTH,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [AW:0]       count,
  output logic              overflow
`ifdef MUX_OUT_FIFO_DROP_CNT_EN
  ,
  output logic [7:0]        drop_cnt
`endif
);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          drop;

  // Handshake gating. A full FIFO refuses writes even when a pop happens in
  // the same cycle, because there is no write-through path. An empty FIFO
  // ignores out_ready.
  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign push      = in_valid & ~full;
  assign pop       = ~empty & out_ready;
  assign drop      = in_valid & full;

  mux_fifo_ctrl #(
    .DEPTH (DEPTH)
  ) u_ctrl (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (push),
    .pop    (pop),
    .wr_ptr (wr_ptr),
    .rd_ptr (rd_ptr),
    .count  (count),
    .full   (full),
    .empty  (empty)
  );

  // Storage is not reset. Data is only observable through out_data while
  // out_valid is high, and every such slot has been written since reset.
  logic [DATA_W-1:0] mem_q [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (push && (wr_ptr == AW'(gi))) begin
          mem_q[gi] <= in_data;
        end
      end
    end
  endgenerate

  // First-word-fall-through: the head is read combinationally.
  assign out_data = mem_q[rd_ptr];

  // Sticky loss flag.
  logic overflow_q, overflow_d;

  always_comb begin
    overflow_d = overflow_q | drop;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign overflow = overflow_q;

`ifdef MUX_OUT_FIFO_DROP_CNT_EN
  // Saturating counter of discarded samples. It holds at 255 rather than
  // wrapping, so a large loss never reads as a small one.
  logic [7:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_cnt_q <= 8'd0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule : mux_out_fifo

// File: tb/tb_mux_out_fifo.sv
// ----------------------------------------------------------------------------
// tb_mux_out_fifo
//   Self-checking bench for mux_out_fifo. A queue-based model follows the
//   FIFO rules. Directed scenarios are followed by randomized traffic. All
//   visible outputs are compared after every clock edge.
// ----------------------------------------------------------------------------
module tb_mux_out_fifo;
  import mux_pkg::*;

  localparam int DEPTH = MUX_FIFO_DEPTH;
  localparam int AW    = $clog2(DEPTH);

  logic            clk = 1'b0;
  logic            rst_n;
  mux_data_t       in_data;
  logic            in_valid;
  logic            in_ready;
  mux_data_t       out_data;
  logic            out_valid;
  logic            out_ready;
  logic [AW:0]     count;
  logic            overflow;
`ifdef MUX_OUT_FIFO_DROP_CNT_EN
  logic [7:0]      drop_cnt;
`endif

  always #5 clk = ~clk;

  mux_out_fifo dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .overflow  (overflow)
`ifdef MUX_OUT_FIFO_DROP_CNT_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  // Reference model state
  mux_data_t model_q[$];
  bit        model_ovf;
  int        model_drops;

  int n_cmp = 0;
  int n_mis = 0;
  int n_txn = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("count",     32'(count),     32'(model_q.size()));
    check("out_valid", 32'(out_valid), 32'(model_q.size() != 0));
    check("in_ready",  32'(in_ready),  32'(model_q.size() != DEPTH));
    check("overflow",  32'(overflow),  32'(model_ovf));
    if (model_q.size() != 0) begin
      check("out_data", 32'(out_data), 32'(model_q[0]));
    end
`ifdef MUX_OUT_FIFO_DROP_CNT_EN
    check("drop_cnt",  32'(drop_cnt),  32'(model_drops));
`endif
  endtask

  // One clock with the given inputs. Inputs are driven just after an edge,
  // and outputs are sampled 1 time unit after the next edge.
  task automatic cycle(input logic v, input mux_data_t d, input logic r);
    bit do_push, do_pop, do_drop;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    do_push = v && (model_q.size() < DEPTH);
    do_pop  = r && (model_q.size() > 0);
    do_drop = v && (model_q.size() == DEPTH);
    @(posedge clk);
    #1;
    if (do_pop)  void'(model_q.pop_front());
    if (do_push) model_q.push_back(d);
    if (do_drop) begin
      model_ovf = 1'b1;
      if (model_drops < 255) model_drops++;
    end
    n_txn++;
    $display("txn %0d: v=%0b d=%02h r=%0b -> count=%0d ov=%0b oread=%0b od=%02h ovf=%0b",
             n_txn, v, d, r, count, out_valid, in_ready, out_data, overflow);
    compare_all();
  endtask

  task automatic reset_dut(input int n);
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    repeat (n) @(posedge clk);
    #1;
    model_q.delete();
    model_ovf   = 1'b0;
    model_drops = 0;
    rst_n = 1'b1;
    $display("txn reset (%0d cycles): count=%0d ov=%0b ir=%0b ovf=%0b",
             n, count, out_valid, in_ready, overflow);
    compare_all();
  endtask

  initial begin
    mux_data_t d;
    // Reset then idle
    reset_dut(2);
    cycle(1'b0, 8'h00, 1'b0);

    // Single sample in, then out
    cycle(1'b1, 8'h0A, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);

    // Fill with 0A..11, then offer 12 while full
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, mux_data_t'(8'h0A + i), 1'b0);
    cycle(1'b1, 8'h12, 1'b0);
    // The full-boundary case: push+pop offered together while full, so no push happens.
    cycle(1'b1, 8'h13, 1'b1);

    // Drain. The head order must be 0B..11 after the pop above.
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 8'h00, 1'b1);

    // Build to count 3, then push and pop together
    for (int i = 0; i < 3; i++) cycle(1'b1, mux_data_t'(8'h20 + i), 1'b0);
    cycle(1'b1, 8'hAC, 1'b1);
    for (int i = 0; i < 20; i++) cycle(1'b1, mux_data_t'($urandom_range(0, 255)), 1'b1);

    // Empty boundary: pop request plus push while empty
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b1, 8'h3C, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);

    // Reset mid-stream at count 5
    for (int i = 0; i < 5; i++) cycle(1'b1, mux_data_t'(8'h40 + i), 1'b0);
    reset_dut(1);
    cycle(1'b1, 8'h55, 1'b0);

    // Randomized traffic with varying pressure and occasional resets
    for (int i = 0; i < 600; i++) begin
      int pv, pr;
      pv = (i / 100) % 2 == 0 ? 80 : 40;
      pr = (i / 100) % 2 == 0 ? 30 : 70;
      d  = mux_data_t'($urandom_range(0, 255));
      if ($urandom_range(0, 199) == 0) begin
        reset_dut(1);
      end else begin
        cycle(logic'($urandom_range(0, 99) < pv), d, logic'($urandom_range(0, 99) < pr));
      end
    end

`ifdef MUX_OUT_FIFO_DROP_CNT_EN
    // Saturation of the drop counter
    reset_dut(1);
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, mux_data_t'(i), 1'b0);
    for (int i = 0; i < 260; i++) cycle(1'b1, 8'hEE, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule : tb_mux_out_fifo
